// File: rtl/graphics_painter_if.sv
// Command/pixel bus between the game controller (plus image ROM) and the
// rectangle painter.
//   master : controller side -- drives the command bundle and ROM data,
//            observes finish/busy and the VRAM/ROM address outputs.
//   slave  : painter side -- the mirror image.
// Signals:
//   en, opcode, tl_x, tl_y, br_x, br_y, arg : command request bundle
//   finish, busy                            : command status
//   vram_we, vram_addr, vram_data           : frame buffer write port
//   rom_addr, rom_data                      : image ROM read port (1-cycle latency)
interface graphics_painter_if #(
    parameter int ROM_AW = 17
);
    logic              en;
    logic              opcode;
    logic [9:0]        tl_x;
    logic [8:0]        tl_y;
    logic [9:0]        br_x;
    logic [8:0]        br_y;
    logic [11:0]       arg;
    logic              finish;
    logic              busy;
    logic              vram_we;
    logic [18:0]       vram_addr;
    logic [11:0]       vram_data;
    logic [ROM_AW-1:0] rom_addr;
    logic [11:0]       rom_data;

    modport master (
        output en, opcode, tl_x, tl_y, br_x, br_y, arg, rom_data,
        input  finish, busy, vram_we, vram_addr, vram_data, rom_addr
    );

    modport slave (
        input  en, opcode, tl_x, tl_y, br_x, br_y, arg, rom_data,
        output finish, busy, vram_we, vram_addr, vram_data, rom_addr
    );
endinterface

// File: rtl/graphics_painter.sv
// Rectangle painter: executes one fill or blit command at a time, writing
// one pixel per clock into a H_RES x V_RES, 12-bit-colour frame buffer.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : graphics_painter_if.slave (command bundle, finish/busy,
//           VRAM write port, image ROM read port)
//
// state  | meaning
// IDLE   | waiting for a re-armed en
// SETUP  | clamp bottom-right corner, compute first row base
// RUN    | visit one pixel per cycle, row-major
// DRAIN  | blit only: last ROM word arrives, final write issued
// DONE   | pulse finish next cycle, return to IDLE
module graphics_painter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ROM_AW = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    graphics_painter_if.slave   bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [9:0]  X_MAX    = 10'(H_RES - 1);
    localparam logic [8:0]  Y_MAX    = 9'(V_RES - 1);
    localparam logic [18:0] ROW_STEP = 19'(H_RES);

    logic [2:0]        state_q, state_d;
    logic              armed_q, armed_d;
    logic              op_q, op_d;
    logic [9:0]        tl_x_q, tl_x_d, br_x_q, br_x_d, x_q, x_d;
    logic [8:0]        tl_y_q, tl_y_d, br_y_q, br_y_d, y_q, y_d;
    logic [11:0]       arg_q, arg_d;
    logic [18:0]       row_base_q, row_base_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              p_valid_q, p_valid_d;
    logic [18:0]       p_addr_q, p_addr_d;
    logic              vram_we_q, vram_we_d;
    logic [18:0]       vram_addr_q, vram_addr_d;
    logic [11:0]       vram_data_q, vram_data_d;
    logic              finish_q, finish_d;
    logic              busy_q, busy_d;

    logic [9:0]        bx;
    logic [8:0]        by;
    logic [18:0]       pix_addr;

    always_comb begin
        state_d     = state_q;
        armed_d     = bus.en ? armed_q : 1'b1;
        op_d        = op_q;
        tl_x_d      = tl_x_q;
        tl_y_d      = tl_y_q;
        br_x_d      = br_x_q;
        br_y_d      = br_y_q;
        arg_d       = arg_q;
        x_d         = x_q;
        y_d         = y_q;
        row_base_d  = row_base_q;
        rom_addr_d  = rom_addr_q;
        p_valid_d   = 1'b0;
        p_addr_d    = p_addr_q;
        vram_we_d   = 1'b0;
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        finish_d    = 1'b0;
        // busy drops on the edge that ends the finish cycle
        busy_d      = busy_q & ~finish_q;
        bx          = (br_x_q > X_MAX) ? X_MAX : br_x_q;
        by          = (br_y_q > Y_MAX) ? Y_MAX : br_y_q;
        pix_addr    = row_base_q + 19'(x_q);

        case (state_q)
            S_IDLE: begin
                if (bus.en && armed_q) begin
                    op_d    = bus.opcode;
                    tl_x_d  = bus.tl_x;
                    tl_y_d  = bus.tl_y;
                    br_x_d  = bus.br_x;
                    br_y_d  = bus.br_y;
                    arg_d   = bus.arg;
                    armed_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                br_x_d = bx;
                br_y_d = by;
                if (tl_x_q > bx || tl_y_q > by) begin
                    state_d = S_DONE;
                end else begin
                    x_d        = tl_x_q;
                    y_d        = tl_y_q;
                    // only multiply in the datapath; rows advance by addition
                    row_base_d = 19'(tl_y_q) * ROW_STEP;
                    rom_addr_d = ROM_AW'({arg_q, 5'b0});
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (op_q) begin
                    // address waits one stage for the registered ROM word
                    p_valid_d  = 1'b1;
                    p_addr_d   = pix_addr;
                    rom_addr_d = rom_addr_q + ROM_AW'(1);
                end else begin
                    vram_we_d   = 1'b1;
                    vram_addr_d = pix_addr;
                    vram_data_d = arg_q;
                end
                if (x_q == br_x_q) begin
                    x_d        = tl_x_q;
                    y_d        = y_q + 9'd1;
                    row_base_d = row_base_q + ROW_STEP;
                    if (y_q == br_y_q) begin
                        state_d = op_q ? S_DRAIN : S_DONE;
                    end
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                finish_d = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (p_valid_q) begin
            vram_we_d   = 1'b1;
            vram_addr_d = p_addr_q;
            vram_data_d = bus.rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b1;
            op_q        <= 1'b0;
            tl_x_q      <= '0;
            tl_y_q      <= '0;
            br_x_q      <= '0;
            br_y_q      <= '0;
            arg_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            rom_addr_q  <= '0;
            p_valid_q   <= 1'b0;
            p_addr_q    <= '0;
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_data_q <= '0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            op_q        <= op_d;
            tl_x_q      <= tl_x_d;
            tl_y_q      <= tl_y_d;
            br_x_q      <= br_x_d;
            br_y_q      <= br_y_d;
            arg_q       <= arg_d;
            x_q         <= x_d;
            y_q         <= y_d;
            row_base_q  <= row_base_d;
            rom_addr_q  <= rom_addr_d;
            p_valid_q   <= p_valid_d;
            p_addr_q    <= p_addr_d;
            vram_we_q   <= vram_we_d;
            vram_addr_q <= vram_addr_d;
            vram_data_q <= vram_data_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.finish    = finish_q;
    assign bus.busy      = busy_q;
    assign bus.vram_we   = vram_we_q;
    assign bus.vram_addr = vram_addr_q;
    assign bus.vram_data = vram_data_q;
    assign bus.rom_addr  = rom_addr_q;
endmodule

// File: tb/tb_graphics_painter.sv
module tb_graphics_painter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    graphics_painter_if #(.ROM_AW(17)) bus ();

    graphics_painter #(.H_RES(640), .V_RES(480), .ROM_AW(17)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  pass_cnt = 0;
    int  total_cnt = 0;
    int  fin_cnt = 0;
    int  busy_cnt = 0;
    int  wr_cnt = 0;

    function automatic logic [11:0] rom_word(input logic [16:0] a);
        return 12'(a + 17'd1);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // registered image ROM: word i holds i+1
    initial begin
        bus.rom_data = '0;
        forever begin
            @(posedge clk);
            bus.rom_data <= rom_word(bus.rom_addr);
        end
    end

    // scoreboard monitor: every observed write must match the next expected one
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (rst_n) begin
            if (bus.finish) fin_cnt = fin_cnt + 1;
            if (bus.busy) busy_cnt = busy_cnt + 1;
            if (bus.vram_we) begin
                wr_cnt = wr_cnt + 1;
                total_cnt = total_cnt + 1;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: cyc %0d addr %0d data %h, none expected",
                             cyc, bus.vram_addr, bus.vram_data);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || bus.vram_addr !== e.addr || bus.vram_data !== e.data)
                        $display("FAIL write: got cyc %0d addr %0d data %h, expected cyc %0d addr %0d data %h",
                                 cyc, bus.vram_addr, bus.vram_data, e.cyc, e.addr, e.data);
                    else
                        pass_cnt = pass_cnt + 1;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_exp(input logic op, input int tlx, input int tly,
                            input int brx, input int bry, input logic [11:0] arg,
                            input int a);
        int bx, by, i;
        logic [16:0] base;
        wr_t e;
        bx = (brx > 639) ? 639 : brx;
        by = (bry > 479) ? 479 : bry;
        base = {arg, 5'b0};
        i = 0;
        for (int y = tly; y <= by; y++) begin
            for (int x = tlx; x <= bx; x++) begin
                e.addr = 19'(y * 640 + x);
                e.data = op ? rom_word(17'(base + 17'(i))) : arg;
                e.cyc  = a + (op ? 3 : 2) + i;
                exp_q.push_back(e);
                i++;
            end
        end
    endtask

    task automatic start_cmd(input logic op, input int tlx, input int tly,
                             input int brx, input int bry, input logic [11:0] arg,
                             output int a);
        @(negedge clk);
        bus.opcode = op;
        bus.tl_x   = 10'(tlx);
        bus.tl_y   = 9'(tly);
        bus.br_x   = 10'(brx);
        bus.br_y   = 9'(bry);
        bus.arg    = arg;
        bus.en     = 1'b1;
        a = cyc + 1;
        busy_cnt = 0;
        push_exp(op, tlx, tly, brx, bry, arg, a);
    endtask

    // returns the finish cycle, or -1 if the budget expires
    task automatic wait_done(input bit drop, input int budget, output int fc);
        fc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.finish) begin
                fc = cyc;
                if (drop) bus.en = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.opcode = 1'b0; bus.arg = '0;
        bus.tl_x = '0; bus.tl_y = '0; bus.br_x = '0; bus.br_y = '0;
        repeat (3) @(negedge clk);
        total_cnt += 6;
        if (bus.finish !== 1'b0) $display("FAIL reset_finish: got %b expected 0", bus.finish); else pass_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        if (bus.vram_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", bus.vram_we); else pass_cnt++;
        if (bus.vram_addr !== 19'd0) $display("FAIL reset_addr: got %0d expected 0", bus.vram_addr); else pass_cnt++;
        if (bus.vram_data !== 12'd0) $display("FAIL reset_data: got %h expected 0", bus.vram_data); else pass_cnt++;
        if (bus.rom_addr !== 17'd0) $display("FAIL reset_rom_addr: got %0d expected 0", bus.rom_addr); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill_top;
        int a, fc, f0;
        f0 = fin_cnt;
        start_cmd(1'b0, 0, 0, 639, 9, 12'hFFF, a);
        wait_done(1'b1, 7000, fc);
        @(negedge clk);
        total_cnt += 5;
        if (fc !== a + 6402) $display("FAIL fill_top_finish: got %0d expected %0d", fc, a + 6402); else pass_cnt++;
        if (exp_q.size() !== 0) $display("FAIL fill_top_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
        if (fin_cnt - f0 !== 1) $display("FAIL fill_top_fin_count: got %0d expected 1", fin_cnt - f0); else pass_cnt++;
        if (busy_cnt !== 6403) $display("FAIL fill_top_busy_cycles: got %0d expected 6403", busy_cnt); else pass_cnt++;
        if (bus.busy !== 1'b0 || bus.finish !== 1'b0)
            $display("FAIL fill_top_after: got busy %b finish %b expected 0 0", bus.busy, bus.finish);
        else pass_cnt++;
    endtask

    task automatic test_fill_wrap;
        int a, fc, f0;
        f0 = fin_cnt;
        start_cmd(1'b0, 351, 0, 639, 2, 12'hFFF, a);
        wait_done(1'b1, 2000, fc);
        @(negedge clk);
        total_cnt += 4;
        if (fc !== a + 869) $display("FAIL fill_wrap_finish: got %0d expected %0d", fc, a + 869); else pass_cnt++;
        if (exp_q.size() !== 0) $display("FAIL fill_wrap_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
        if (fin_cnt - f0 !== 1) $display("FAIL fill_wrap_fin_count: got %0d expected 1", fin_cnt - f0); else pass_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL fill_wrap_busy_after: got %b expected 0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_blit;
        int a, fc;
        start_cmd(1'b1, 0, 0, 3, 1, 12'h000, a);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(a + 1 + i);
            total_cnt++;
            if (bus.rom_addr !== 17'(i)) $display("FAIL blit_rom_addr: got %0d expected %0d", bus.rom_addr, i);
            else pass_cnt++;
        end
        wait_done(1'b1, 100, fc);
        @(negedge clk);
        total_cnt += 3;
        if (fc !== a + 11) $display("FAIL blit_finish: got %0d expected %0d", fc, a + 11); else pass_cnt++;
        if (exp_q.size() !== 0) $display("FAIL blit_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
        if (busy_cnt !== 12) $display("FAIL blit_busy_cycles: got %0d expected 12", busy_cnt); else pass_cnt++;
        // base 0x1FFE0: ROM address wraps to 0 after 32 pixels
        start_cmd(1'b1, 0, 100, 47, 100, 12'hFFF, a);
        wait_done(1'b1, 200, fc);
        @(negedge clk);
        total_cnt += 2;
        if (fc !== a + 51) $display("FAIL blit_wrap_finish: got %0d expected %0d", fc, a + 51); else pass_cnt++;
        if (exp_q.size() !== 0) $display("FAIL blit_wrap_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_clamp;
        int a, fc, w0;
        start_cmd(1'b0, 630, 470, 700, 500, 12'h00F, a);
        wait_done(1'b1, 300, fc);
        @(negedge clk);
        total_cnt += 2;
        if (fc !== a + 102) $display("FAIL clamp_finish: got %0d expected %0d", fc, a + 102); else pass_cnt++;
        if (exp_q.size() !== 0) $display("FAIL clamp_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
        w0 = wr_cnt;
        start_cmd(1'b0, 5, 0, 4, 0, 12'h123, a);
        wait_done(1'b1, 50, fc);
        @(negedge clk);
        total_cnt += 3;
        if (fc !== a + 2) $display("FAIL empty_finish: got %0d expected %0d", fc, a + 2); else pass_cnt++;
        if (wr_cnt - w0 !== 0) $display("FAIL empty_writes: got %0d expected 0", wr_cnt - w0); else pass_cnt++;
        if (busy_cnt !== 3) $display("FAIL empty_busy_cycles: got %0d expected 3", busy_cnt); else pass_cnt++;
    endtask

    task automatic test_handshake;
        int a, fc, f0;
        f0 = fin_cnt;
        start_cmd(1'b0, 20, 20, 22, 20, 12'hABC, a);
        wait_done(1'b0, 50, fc);
        repeat (5) @(negedge clk);
        total_cnt += 3;
        if (fc !== a + 5) $display("FAIL hold_finish: got %0d expected %0d", fc, a + 5); else pass_cnt++;
        if (fin_cnt - f0 !== 1) $display("FAIL hold_no_retrigger: got %0d finishes expected 1", fin_cnt - f0); else pass_cnt++;
        if (busy_cnt !== 6) $display("FAIL hold_busy_cycles: got %0d expected 6", busy_cnt); else pass_cnt++;
        bus.en = 1'b0;
        start_cmd(1'b0, 30, 30, 31, 30, 12'h456, a);
        wait_cyc(a);
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL rearm_accept: got busy %b expected 1", bus.busy); else pass_cnt++;
        wait_done(1'b1, 50, fc);
        @(negedge clk);
        total_cnt++;
        if (fc !== a + 4) $display("FAIL rearm_finish: got %0d expected %0d", fc, a + 4); else pass_cnt++;
        start_cmd(1'b0, 10, 10, 13, 11, 12'h7E1, a);
        wait_cyc(a + 3);
        bus.en = 1'b0;
        wait_done(1'b1, 50, fc);
        @(negedge clk);
        total_cnt += 2;
        if (fc !== a + 10) $display("FAIL drop_en_finish: got %0d expected %0d", fc, a + 10); else pass_cnt++;
        if (exp_q.size() !== 0) $display("FAIL drop_en_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_blit;
        int a, fc, f0;
        f0 = fin_cnt;
        start_cmd(1'b1, 0, 0, 3, 1, 12'h000, a);
        wait_cyc(a + 5);
        #2 rst_n = 1'b0;
        #1;
        total_cnt += 4;
        if (bus.vram_we !== 1'b0 || bus.vram_addr !== 19'd0 || bus.vram_data !== 12'd0)
            $display("FAIL midrst_vram: got we %b addr %0d data %h expected 0 0 0",
                     bus.vram_we, bus.vram_addr, bus.vram_data);
        else pass_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.busy); else pass_cnt++;
        if (bus.rom_addr !== 17'd0) $display("FAIL midrst_rom_addr: got %0d expected 0", bus.rom_addr); else pass_cnt++;
        if (bus.finish !== 1'b0) $display("FAIL midrst_finish: got %b expected 0", bus.finish); else pass_cnt++;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a = cyc + 1;
        busy_cnt = 0;
        push_exp(1'b1, 0, 0, 3, 1, 12'h000, a);
        wait_done(1'b1, 100, fc);
        @(negedge clk);
        total_cnt += 3;
        if (fc !== a + 11) $display("FAIL midrst_restart_finish: got %0d expected %0d", fc, a + 11); else pass_cnt++;
        if (fin_cnt - f0 !== 1) $display("FAIL midrst_fin_count: got %0d expected 1", fin_cnt - f0); else pass_cnt++;
        if (exp_q.size() !== 0) $display("FAIL midrst_missing: got %0d left expected 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill_top();
        test_fill_wrap();
        test_blit();
        test_clamp();
        test_handshake();
        test_reset_mid_blit();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/graphics_painter.md
# graphics_painter

- Executes one rectangle command at a time from the game controller: solid fill, or blit from image ROM.
- Writes pixels one per clock into the 640x480, 12-bit-colour frame buffer (VRAM).
- Sits directly downstream of the controller; consumes its en/opcode/rectangle/arg bundle and returns a one-cycle finish pulse.

## Interface
Parameters:
- H_RES, 640: frame width in pixels; VRAM row stride.
- V_RES, 480: frame height in pixels.
- ROM_AW, 17: image ROM address width.

Ports:
- clk  in  1  system clock; everything on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  command request; level, held by the controller until it sees finish.
- opcode  in  1  command: 0 = fill, 1 = blit.
- tl_x  in  10  left column, inclusive.
- tl_y  in  9  top row, inclusive.
- br_x  in  10  right column, inclusive.
- br_y  in  9  bottom row, inclusive.
- arg  in  12  fill: RGB444 colour; blit: ROM base, start address = {arg, 5'b0}.
- finish  out  1  one-cycle pulse when the command completes.
- busy  out  1  high from command acceptance until the finish cycle, inclusive.
- vram_we  out  1  pixel write strobe.
- vram_addr  out  19  write address = y*H_RES + x.
- vram_data  out  12  pixel colour.
- rom_addr  out  ROM_AW  image ROM read address.
- rom_data  in  12  ROM output; 1-cycle registered latency.

## Operation
- States: IDLE, SETUP, RUN, DRAIN, DONE.
- IDLE:
  - en=1 and armed=1: latch opcode, rectangle and arg; clear armed; go to SETUP.
  - armed sets on any cycle with en=0; reset value 1.
- SETUP, clamping:
  - br_x clamps to H_RES-1; br_y clamps to V_RES-1.
  - Empty rectangle (tl_x>clamped br_x, or tl_y>clamped br_y) goes straight to DONE with no writes.
  - Otherwise: x=tl_x, y=tl_y, row_base=tl_y*H_RES; go to RUN.
  - row_base is one multiply in SETUP only. Rows then advance by adding H_RES; no per-pixel multiply.
- RUN visits one pixel per cycle, row-major.
  - x increments; at x==br_x, x reloads tl_x, y increments and row_base += H_RES.
  - At the last pixel (x==br_x, y==br_y): fill goes to DONE; blit goes to DRAIN.
- Fill: vram_we=1, vram_addr=row_base+x, vram_data=arg, all registered in the same cycle the pixel is visited.
- Blit:
  - rom_addr starts at {arg,5'b0} and increments once per visited pixel.
  - The VRAM address is delayed one stage to align with rom_data; vram_data=rom_data.
  - DRAIN issues the final write.
- DONE: finish=1 for exactly one cycle, then IDLE.
- en falling mid-command is ignored; the latched command completes and finish still pulses.
- Arithmetic: vram_addr is 19 bits, maximum 307199. rom_addr wraps modulo 2^ROM_AW.

## Timing
- Reset values: finish=0, busy=0, vram_we=0, vram_addr=0, vram_data=0, rom_addr=0, armed=1, state=IDLE.
- Let N = pixel count and edge A = the edge that samples en=1.
- Fill: writes in cycles A+2 .. A+N+1; finish in cycle A+N+2.
- Blit: writes in cycles A+3 .. A+N+2; finish in cycle A+N+3.
- Empty rectangle: finish in cycle A+2; vram_we never asserts.
- The controller drops en on the edge ending the finish cycle. finish is already 0 in the next cycle, so the controller's following state does not see a stale finish.
- A new command needs en low for at least one cycle (re-arm), so en held high across finish never double-triggers.
- Reset asserted mid-command: all outputs go to reset values immediately (asynchronous); no finish. After release, a still-high en is accepted as a new command.

## Test plan
- Reset, then fill (0,0)-(639,479) with FFF: 307200 writes; first addr 0, last addr 307199; finish one cycle after the last write, exactly once.
- Fill (351,0)-(639,479) with FFF: first addr 351; at the row wrap, addr 639 is followed by 991; finish pulse width 1; busy low the cycle after finish.
- Blit (0,0)-(3,1) with arg=0 and ROM word i = i+1: writes 1..8 at addrs 0,1,2,3,640,641,642,643; rom_addr 0..7; finish at A+11.
- Clamping: fill (630,470)-(700,500) with 00F writes only 10x10 pixels, ending at addr 307199. Fill with tl_x=5, br_x=4 gives finish at A+2 with zero writes.
- Handshake: en held high for 5 cycles after finish gives no second command; en low 1 cycle then high again gives a new accept. en dropped during RUN still gives full writes plus finish.
- Reset mid-blit at pixel 3: outputs zero immediately, no finish; en still high after release restarts the command from its first pixel.
